// File: rtl/mem_interface_if.sv
// Memory-side handshake bus of mem_interface: request/write-enable/address/data
// out towards memory, completion strobe and read data back.
interface mem_interface_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 9
);
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_ack;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/mem_interface.sv
// CPU-side MAR/MDR pair with a request/acknowledge memory handshake.
// A read or write started from IDLE holds mem_req until mem_ack, or gives up
// with a one-cycle error pulse after TIMEOUT unacknowledged request cycles.
module mem_interface #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 9,
  parameter int TIMEOUT    = 15
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic [DATA_WIDTH-1:0] BusMuxOut,
  input  logic                  MARin,
  input  logic                  MDRin,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic                  MDRout,
  mem_interface_if.master       mem,
  output logic [DATA_WIDTH-1:0] BusMuxIn_MDR,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  typedef enum logic [1:0] {IDLE, REQ, DONE, ERR} state_t;

  // Counter value in the last permitted request cycle (counter starts at 0).
  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

  state_t                state, state_n;
  logic [ADDR_WIDTH-1:0] mar;
  logic [DATA_WIDTH-1:0] mdr;
  logic                  we_q;
  logic [7:0]            wait_cnt;

  // State register
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) state <= IDLE;
    else        state <= state_n;
  end

  // Next state and state-decoded outputs; ack wins over timeout in the last wait cycle
  always_comb begin
    state_n = state;
    busy    = 1'b0;
    done    = 1'b0;
    error   = 1'b0;
    unique case (state)
      IDLE: begin
        if (MemRead || MemWrite) state_n = REQ;
      end
      REQ: begin
        busy = 1'b1;
        if (mem.mem_ack)                state_n = DONE;
        else if (wait_cnt == LAST_WAIT) state_n = ERR;
      end
      DONE: begin
        done    = 1'b1;
        state_n = IDLE;
      end
      ERR: begin
        error   = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // MAR/MDR loads, read-data capture, direction latch and wait counter
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      mar      <= '0;
      mdr      <= '0;
      we_q     <= 1'b0;
      wait_cnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (MARin) mar <= BusMuxOut[ADDR_WIDTH-1:0];
          if (MDRin) mdr <= BusMuxOut;
          if (MemRead)       we_q <= 1'b0;
          else if (MemWrite) we_q <= 1'b1;
          wait_cnt <= '0;
        end
        REQ: begin
          if (mem.mem_ack) begin
            if (!we_q) mdr <= mem.mem_rdata;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem.mem_req   = busy;
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = mar;
  assign mem.mem_wdata = mdr;
  assign BusMuxIn_MDR  = mdr & {DATA_WIDTH{MDRout}};

endmodule

// File: tb/tb_mem_interface.sv
// Bench for mem_interface: directed and random read/write transactions against
// a transaction-level model of MAR/MDR and the request length rules.
module tb_mem_interface;
  localparam int DW = 32;
  localparam int AW = 9;
  localparam int TO = 15;

  logic          clock = 1'b0;
  logic          clear;
  logic [DW-1:0] BusMuxOut;
  logic          MARin, MDRin, MemRead, MemWrite, MDRout;
  logic [DW-1:0] BusMuxIn_MDR;
  logic          busy, done, error;

  mem_interface_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) mif ();

  mem_interface #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
    .clock       (clock),
    .clear       (clear),
    .BusMuxOut   (BusMuxOut),
    .MARin       (MARin),
    .MDRin       (MDRin),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .MDRout      (MDRout),
    .mem         (mif.master),
    .BusMuxIn_MDR(BusMuxIn_MDR),
    .busy        (busy),
    .done        (done),
    .error       (error)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  // Model of the visible registers
  logic [AW-1:0] mar_m;
  logic [DW-1:0] mdr_m;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #2;
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".req"},   64'(mif.mem_req), 64'(0));
    check({tag, ".busy"},  64'(busy), 64'(0));
    check({tag, ".done"},  64'(done), 64'(0));
    check({tag, ".error"}, 64'(error), 64'(0));
    check({tag, ".addr"},  64'(mif.mem_addr), 64'(mar_m));
    check({tag, ".wdata"}, 64'(mif.mem_wdata), 64'(mdr_m));
    MDRout = 1'b1;
    #1;
    check({tag, ".busin1"}, 64'(BusMuxIn_MDR), 64'(mdr_m));
    MDRout = 1'b0;
    #1;
    check({tag, ".busin0"}, 64'(BusMuxIn_MDR), 64'(0));
    MDRout = 1'b1;
  endtask

  task automatic clear_inputs;
    MARin = 1'b0; MDRin = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
  endtask

  task automatic load(input bit ld_mar, input bit ld_mdr, input logic [DW-1:0] bus);
    BusMuxOut = bus; MARin = ld_mar; MDRin = ld_mdr;
    tick;
    if (ld_mar) mar_m = bus[AW-1:0];
    if (ld_mdr) mdr_m = bus;
    clear_inputs();
    check_idle("load");
  endtask

  // One transaction from IDLE. ack_at = REQ cycle (1-based) carrying mem_ack,
  // 0 = never. Acks later than TO cycles never reach the bus (timeout first).
  task automatic run_txn(input bit rd, input bit wr, input bit ld_mar, input bit ld_mdr,
                         input logic [DW-1:0] bus, input int ack_at,
                         input logic [DW-1:0] rdata, input bit noise);
    bit ends_done;
    int req_len;
    bit exp_we;
    ends_done = (ack_at >= 1) && (ack_at <= TO);
    req_len   = ends_done ? ack_at : TO;
    exp_we    = !rd;
    BusMuxOut = bus; MARin = ld_mar; MDRin = ld_mdr; MemRead = rd; MemWrite = wr;
    tick;
    if (ld_mar) mar_m = bus[AW-1:0];
    if (ld_mdr) mdr_m = bus;
    clear_inputs();
    for (int k = 1; k <= req_len; k++) begin
      check("txn.req",   64'(mif.mem_req), 64'(1));
      check("txn.busy",  64'(busy), 64'(1));
      check("txn.we",    64'(mif.mem_we), 64'(exp_we));
      check("txn.addr",  64'(mif.mem_addr), 64'(mar_m));
      check("txn.wdata", 64'(mif.mem_wdata), 64'(mdr_m));
      check("txn.done0", 64'(done), 64'(0));
      check("txn.err0",  64'(error), 64'(0));
      if (noise) begin
        BusMuxOut = $urandom;
        MARin     = 1'($urandom_range(0, 1));
        MDRin     = 1'($urandom_range(0, 1));
        MemRead   = 1'($urandom_range(0, 1));
        MemWrite  = 1'($urandom_range(0, 1));
        mif.mem_rdata = $urandom;
      end
      if (k == ack_at) begin
        mif.mem_ack   = 1'b1;
        mif.mem_rdata = rdata;
      end
      tick;
      mif.mem_ack = 1'b0;
      clear_inputs();
    end
    if (ends_done && rd) mdr_m = rdata;
    check("end.done",  64'(done), 64'(ends_done));
    check("end.error", 64'(error), 64'(!ends_done));
    check("end.req",   64'(mif.mem_req), 64'(0));
    check("end.addr",  64'(mif.mem_addr), 64'(mar_m));
    check("end.wdata", 64'(mif.mem_wdata), 64'(mdr_m));
    tick;
    check_idle("post");
  endtask

  initial begin
    clear = 1'b0;
    BusMuxOut = '0;
    clear_inputs();
    MDRout = 1'b1;
    mif.mem_ack = 1'b0;
    mif.mem_rdata = '0;
    mar_m = '0;
    mdr_m = '0;
    #1;
    check_idle("reset");
    #8;
    clear = 1'b1;

    // Read at 0x05, ack in third request cycle
    load(1'b1, 1'b0, 32'h0000_0005);
    run_txn(1'b1, 1'b0, 1'b0, 1'b0, '0, 3, 32'hDEAD_BEEF, 1'b0);

    // Write 0x12345678 to 0x1FF
    load(1'b0, 1'b1, 32'h1234_5678);
    load(1'b1, 1'b0, 32'h0000_01FF);
    run_txn(1'b0, 1'b1, 1'b0, 1'b0, '0, 4, 32'hCAFE_F00D, 1'b0);

    // Timeout without ack, then ack exactly in the last allowed cycle
    run_txn(1'b1, 1'b0, 1'b0, 1'b0, '0, 0, 32'h0, 1'b0);
    run_txn(1'b1, 1'b0, 1'b0, 1'b0, '0, TO, 32'hA5A5_5A5A, 1'b0);

    // Minimum transaction, read+write collision, noisy inputs during REQ
    run_txn(1'b1, 1'b1, 1'b0, 1'b0, '0, 1, 32'h0BAD_CAFE, 1'b0);
    run_txn(1'b0, 1'b1, 1'b1, 1'b1, 32'h7777_0123, 5, 32'h1111_2222, 1'b1);

    // Ack while idle is ignored
    mif.mem_ack = 1'b1;
    mif.mem_rdata = 32'hFFFF_FFFF;
    tick;
    mif.mem_ack = 1'b0;
    check_idle("idle_ack");

    // Clear in the second request cycle
    MemRead = 1'b1;
    tick;
    clear_inputs();
    tick;
    check("rst.req_before", 64'(mif.mem_req), 64'(1));
    clear = 1'b0;
    #1;
    mar_m = '0;
    mdr_m = '0;
    check_idle("rst_async");
    tick;
    clear = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      check_idle("rst_after");
    end

    // Random transactions
    for (int n = 0; n < 25; n++) begin
      int unsigned op;
      op = $urandom_range(1, 3);
      run_txn(1'(op & 1), 1'((op >> 1) & 1),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom,
              int'($urandom_range(0, TO + 3)), $urandom, 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
